mips32_fetch_queue: RTL and testbench
=====================================

Name: mips32_fetch_queue

Overview:
- Instruction-fetch front end for the pipelined MIPS32 core. It sits between the word-addressed instruction memory and the ID stage.
- Owns the PC and issues one word fetch per cycle.
- Buffers returned instructions, each paired with its NPC (PC+1), in a small FIFO.
- Presents them to decode over a valid/ready handshake.
- A taken branch (redirect) flushes everything and restarts fetch at the target. Replaces the bare mem[PC] read in the fetch stage so decode can stall without losing instructions.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
AW, 10, instruction-memory word-address width (1024 words)
RESET_PC, 32'h0, PC value loaded on reset

Ports:
clk1  input  1  single core clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
halt  input  1  level; while high no new fetch requests are issued
redirect_valid  input  1  one-cycle pulse: taken branch
redirect_pc  input  32  branch target word address (EX_MEM ALUOut)
imem_req  output  1  fetch request, address valid
imem_addr  output  AW  = PC[AW-1:0]
imem_gnt  input  1  request accepted this cycle when imem_req & imem_gnt
imem_rvalid  input  1  read data valid; asserted exactly 1 cycle after each accepted request
imem_rdata  input  32  instruction word
out_valid  output  1  instruction available to ID
out_ir  output  32  instruction word (IF_ID_IR)
out_npc  output  32  fetch address + 1 (IF_ID_NPC)
out_ready  input  1  ID accepts; pop when out_valid & out_ready

Behaviour:
- Reset (rst high at posedge):
  - PC = RESET_PC.
  - FIFO count = 0, rd/wr pointers = 0, inflight = 0, drop = 0.
  - out_valid = 0, imem_req = 0, out_ir/out_npc = 0.
- Credit rule: imem_req = !rst & !halt & !redirect_valid & (count + inflight < DEPTH).
  - Counts are taken after this cycle's pop is excluded (pop does not free a credit in the same cycle).
  - FIFO can never overflow; no push is ever dropped for lack of space.
- Accepted request (req & gnt):
  - PC <= PC + 1, with 32-bit wrap: 32'hFFFFFFFF -> 0.
  - inflight <= 1.
  - Tag register holds fetch address + 1 for the response.
- Response (imem_rvalid):
  - If drop = 0, push {imem_rdata, tag} into the FIFO.
  - If drop = 1, discard the response and clear drop.
  - inflight <= 0 unless a new request is accepted the same cycle.
- Latency: request accepted at cycle t -> rvalid at t+1 -> out_valid at t+2. No bypass path.
- Output:
  - out_valid = (count != 0); out_ir/out_npc = head entry, registered.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- Redirect (redirect_valid high at a posedge):
  - FIFO is flushed: count = 0, pointers = 0, so out_valid = 0 next cycle.
  - PC <= redirect_pc.
  - If a request was accepted in the previous cycle (response due now or next), drop <= 1 for a response not yet returned. A response arriving in the redirect cycle itself is discarded.
  - imem_req is low in the redirect cycle; the target is requested from the next cycle on.
  - A pop handshake in the redirect cycle still completes. ID must itself squash it (the TAKEN_BRANCH rule).
  - Redirect has priority over push, pop and halt.
- Halt:
  - Blocks new requests only.
  - An in-flight response is still pushed.
  - The FIFO keeps draining to ID.
  - PC holds.
  - Deasserting halt resumes fetch at the held PC.
- Reset mid-operation: all state cleared regardless of inflight/redirect/halt. A response arriving in the cycle after reset is ignored (inflight = 0).
- Arithmetic: the PC is full 32-bit and only the low AW bits address memory. NPC is 32-bit PC+1.

Test Plan:
- Reset, then streaming: RESET_PC=0, gnt=1, out_ready=1, mem[i]=i+100 -> imem_req rises 1 cycle after reset release; first out_valid 2 cycles after first grant with out_ir=100, out_npc=1; then one instruction per cycle.
- Backpressure full: out_ready=0 for 10 cycles -> exactly 4 entries buffered, imem_req low, PC=4; release ready -> ir 100,101,102,103 in order, no duplicate or skip, then 104.
- Redirect with response in flight: redirect_pc=40 one cycle after the grant of addr 7 -> word 7 never appears, FIFO flushed, next out_ir=mem[40], out_npc=41.
- Redirect while full and out_ready=0: out_valid=0 the cycle after redirect; first new output is mem[target].
- Halt during streaming: halt=1 for 5 cycles -> no requests, the outstanding response is delivered, PC frozen; halt=0 -> fetch resumes at the frozen PC with no gaps.
- Wrap: redirect_pc=32'hFFFFFFFE -> imem_addr 10'h3FE, 10'h3FF, 10'h000; out_npc FFFFFFFF, 0, 1.

Source files
------------

// File: rtl/mips32_fetch_queue.sv
// rtl/mips32_fetch_queue.sv - MIPS32 instruction-fetch front end: PC, credit-limited fetch, instruction FIFO
//
// Purpose: owns the fetch PC, issues at most one word fetch per cycle to the
// instruction memory, buffers returned words with their NPC (fetch address + 1)
// and hands them to ID over a valid/ready handshake. A redirect (taken branch)
// flushes the buffer and restarts fetch at the branch target.
//
// Ports:
//   clk1           core clock, all state updates on posedge
//   rst            synchronous active-high reset
//   halt           level; suppresses new fetch requests only
//   redirect_valid one-cycle taken-branch pulse
//   redirect_pc    branch target word address
//   imem_req       fetch request (address valid)
//   imem_addr      low AW bits of the PC
//   imem_gnt       request accepted when imem_req & imem_gnt
//   imem_rvalid    read data valid, exactly one cycle after an accepted request
//   imem_rdata     instruction word from memory
//   out_valid      instruction available to ID
//   out_ir         head instruction word
//   out_npc        head instruction fetch address + 1
//   out_ready      ID accepts; pop when out_valid & out_ready

module mips32_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 10,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          halt,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic          out_valid,
  output logic [31:0]   out_ir,
  output logic [31:0]   out_npc,
  input  logic          out_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   pc_inc;
  logic [31:0]   tag;        // NPC of the request whose response is due next cycle
  logic          inflight;   // a response will arrive this cycle
  logic          drop;       // next response belongs to a flushed stream
  logic [31:0]   ir_mem  [DEPTH];
  logic [31:0]   npc_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic          accept;
  logic          push;
  logic          pop;

  // An in-flight request already owns a slot, so the FIFO can never overflow.
  // The registered count is used, so a pop frees its slot only next cycle.
  always_comb begin
    credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
    imem_req    = !rst && !halt && !redirect_valid && (credit_used < DEPTH_C);
  end

  assign imem_addr = pc[AW-1:0];
  assign pc_inc    = pc + 32'd1;
  assign accept    = imem_req && imem_gnt;
  // A response landing in the redirect cycle belongs to the old stream.
  assign push      = imem_rvalid && inflight && !drop && !redirect_valid;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_ir    = out_valid ? ir_mem[rd_ptr]  : 32'd0;
  assign out_npc   = out_valid ? npc_mem[rd_ptr] : 32'd0;

  always_ff @(posedge clk1) begin
    if (push) begin
      ir_mem[wr_ptr]  <= imem_rdata;
      npc_mem[wr_ptr] <= tag;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      pc       <= RESET_PC;
      tag      <= 32'd0;
      inflight <= 1'b0;
      drop     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (redirect_valid) begin
        pc <= redirect_pc;
      end else if (accept) begin
        pc <= pc_inc;
      end

      if (accept) begin
        tag <= pc_inc;
      end

      if (accept) begin
        inflight <= 1'b1;
      end else if (imem_rvalid) begin
        inflight <= 1'b0;
      end

      // Only a response still outstanding after the redirect cycle needs
      // to be marked; one arriving now is already discarded by push.
      if (redirect_valid) begin
        drop <= inflight && !imem_rvalid;
      end else if (imem_rvalid) begin
        drop <= 1'b0;
      end

      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !push) begin
          count <= count - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// tb/tb_mips32_fetch_queue.sv - scoreboard testbench for mips32_fetch_queue

module tb_mips32_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          AW       = 10;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic          clk1 = 1'b0;
  logic          rst = 1'b1;
  logic          halt = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'd0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = 32'd0;
  logic          out_valid;
  logic [31:0]   out_ir;
  logic [31:0]   out_npc;
  logic          out_ready = 1'b0;

  always #5 clk1 = ~clk1;

  mips32_fetch_queue #(
    .DEPTH(DEPTH),
    .AW(AW),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk1(clk1),
    .rst(rst),
    .halt(halt),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .out_valid(out_valid),
    .out_ir(out_ir),
    .out_npc(out_npc),
    .out_ready(out_ready)
  );

  // Reference: the fetch stream is the sequence of consecutive addresses
  // since the last reset/redirect. Each granted fetch becomes an expected
  // ID delivery, visible two cycles after its grant; a flush discards all
  // deliveries not yet taken by ID.
  typedef struct {
    logic [31:0] ir;
    logic [31:0] npc;
    int          rdy;
  } ent_t;

  ent_t          q[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  logic [31:0]   model_pc = 32'd0;
  bit            mon_en = 1'b0;
  bit            pend = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  bit            spur = 1'b0;

  always @(posedge clk1) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'(a) + 32'd100;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check the fetch request,
  // act as the memory, then advance the reference model.
  task automatic drive(input bit r, input bit h, input bit rv, input logic [31:0] rp,
                       input bit rd, input bit g);
    bit acc;
    bit exp_req;
    @(negedge clk1);
    rst            = r;
    halt           = h;
    redirect_valid = rv;
    redirect_pc    = rp;
    out_ready      = rd;
    imem_gnt       = g;
    imem_rvalid    = pend || spur;
    imem_rdata     = pend ? mem_word(pend_addr) : $urandom;
    spur           = 1'b0;
    #1;
    exp_req = !r && !h && !rv && (q.size() < DEPTH);
    check(imem_req === exp_req, "imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req && imem_req === 1'b1)
      check(imem_addr === model_pc[AW-1:0], "imem_addr", 32'(imem_addr), 32'(model_pc[AW-1:0]));
    acc       = (imem_req === 1'b1) && g;
    pend      = acc;
    pend_addr = imem_addr;
    #2;
    if (r) begin
      q.delete();
      model_pc = RESET_PC;
    end else if (rv) begin
      q.delete();
      model_pc = rp;
    end else if (acc) begin
      q.push_back('{mem_word(model_pc[AW-1:0]), model_pc + 32'd1, cyc + 2});
      model_pc = model_pc + 32'd1;
    end
  endtask

  // Monitor: compares whatever the DUT presents to ID against the scoreboard.
  initial begin
    bit ev;
    forever begin
      @(negedge clk1);
      #2;
      if (mon_en) begin
        if (q.size() > 0) ev = (q[0].rdy <= cyc);
        else              ev = 1'b0;
        check(out_valid === ev, "out_valid", {31'b0, out_valid}, {31'b0, ev});
        if (ev && out_valid === 1'b1) begin
          check(out_ir === q[0].ir, "out_ir", out_ir, q[0].ir);
          check(out_npc === q[0].npc, "out_npc", out_npc, q[0].npc);
          if (out_ready) q.delete(0);
        end
      end
    end
  end

  initial begin
    bit          r, h, rv, rd, g, last_r;
    logic [31:0] rp;

    drive(1, 0, 0, 32'd0, 1, 1);
    mon_en = 1'b1;
    drive(1, 0, 0, 32'd0, 1, 1);
    check(out_ir === 32'd0, "reset_out_ir", out_ir, 32'd0);
    check(out_npc === 32'd0, "reset_out_npc", out_npc, 32'd0);

    repeat (20) drive(0, 0, 0, 32'd0, 1, 1);

    // mid-operation reset, stray response right after it, then backpressure
    drive(1, 0, 0, 32'd0, 1, 1);
    spur = 1'b1;
    repeat (10) drive(0, 0, 0, 32'd0, 0, 1);
    repeat (12) drive(0, 0, 0, 32'd0, 1, 1);

    // redirect one cycle after a grant (response in flight)
    drive(0, 0, 1, 32'd40, 1, 1);
    repeat (10) drive(0, 0, 0, 32'd0, 1, 1);

    // redirect while full and ID stalled
    repeat (8) drive(0, 0, 0, 32'd0, 0, 1);
    drive(0, 0, 1, 32'd200, 0, 1);
    repeat (10) drive(0, 0, 0, 32'd0, 1, 1);

    // halt during streaming
    repeat (5) drive(0, 1, 0, 32'd0, 1, 1);
    repeat (8) drive(0, 0, 0, 32'd0, 1, 1);

    // PC wrap
    drive(0, 0, 1, 32'hFFFF_FFFE, 1, 1);
    repeat (8) drive(0, 0, 0, 32'd0, 1, 1);

    // randomized traffic
    last_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      h  = ($urandom_range(0, 99) < 10);
      rv = ($urandom_range(0, 99) < 5);
      rd = ($urandom_range(0, 3) != 0);
      g  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else                           rp = $urandom;
      if (last_r && !r) spur = 1'b1;
      drive(r, h, rv, rp, rd, g);
      last_r = r;
    end

    repeat (8) drive(0, 0, 0, 32'd0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
